regwrite_trace_buffer: RTL and testbench

//   Captures every retired register-file write from the pipelined processor's

---
 rtl/regwrite_trace_buffer.sv | 121 ++++++++++++
 tb/tb_regwrite_trace_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regwrite_trace_buffer.sv
// Regfile-write trace FIFO: captures writeback writes with a cycle stamp.
// Define TRACE_SKIP_R0_EN to ignore writes to register 0.
module regwrite_trace_buffer #(
   parameter int DEPTH   = 16,
   parameter int STAMP_W = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     ctrl_writeEnable,
   input  logic [4:0]               ctrl_writeReg,
   input  logic [31:0]              data_writeReg,
   input  logic                     trace_enable,
   input  logic                     clear,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [4:0]               out_reg,
   output logic [31:0]              out_data,
   output logic [STAMP_W-1:0]       out_stamp,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [15:0]              drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [4:0]         rg;
      logic [31:0]        data;
      logic [STAMP_W-1:0] stamp;
   } entry_t;

   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               overflow_q, overflow_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;
   logic [STAMP_W-1:0] stamp_q, stamp_d;

   logic capture, full, pop, push, drop;

`ifdef TRACE_SKIP_R0_EN
   assign capture = trace_enable & ctrl_writeEnable & (ctrl_writeReg != 5'd0);
`else
   assign capture = trace_enable & ctrl_writeEnable;
`endif

   assign full      = (count_q == CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready;
   // A full FIFO still accepts a write when the head leaves in the same cycle
   assign push      = capture & (~full | pop);
   assign drop      = capture & full & ~pop;

   assign out_reg    = out_valid ? mem_q[rd_ptr_q].rg    : '0;
   assign out_data   = out_valid ? mem_q[rd_ptr_q].data  : '0;
   assign out_stamp  = out_valid ? mem_q[rd_ptr_q].stamp : '0;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_cnt_q;

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      stamp_d    = stamp_q + 1'b1;
      if (clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
         stamp_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = '{rg: ctrl_writeReg,
                                data: data_writeReg,
                                stamp: stamp_q};
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         stamp_q    <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         stamp_q    <= stamp_d;
      end
   end

endmodule

// File: tb/tb_regwrite_trace_buffer.sv
// Directed bench for regwrite_trace_buffer.
// Expected values are hand-derived from the stamp/cycle sequence.
module tb_regwrite_trace_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        trace_enable;
   logic        clear;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_reg;
   logic [31:0] out_data;
   logic [15:0] out_stamp;
   logic [4:0]  count;
   logic        overflow;
   logic [15:0] drop_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   regwrite_trace_buffer #(.DEPTH(16), .STAMP_W(16)) dut (
      .clock(clock),
      .reset(reset),
      .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg),
      .trace_enable(trace_enable),
      .clear(clear),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_reg(out_reg),
      .out_data(out_data),
      .out_stamp(out_stamp),
      .count(count),
      .overflow(overflow),
      .drop_count(drop_count)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] d);
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = r;
      data_writeReg    = d;
      tick();
      ctrl_writeEnable = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg = '0;
      data_writeReg = '0;
      trace_enable = 1'b0;
      clear = 1'b0;
      out_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      // 1: reset state, stamp now 0
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      chk("rst_reg", 64'(out_reg), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_stamp", 64'(out_stamp), 64'd0);

      // disabled trace ignores writes (stamp 0 -> 1)
      wr(5'd4, 32'd99);
      chk("dis_count", 64'(count), 64'd0);

      // 2: single write at stamp 5
      trace_enable = 1'b1;
      repeat (4) tick();
      wr(5'd2, 32'd150);
      chk("w1_valid", 64'(out_valid), 64'd1);
      chk("w1_reg", 64'(out_reg), 64'd2);
      chk("w1_data", 64'(out_data), 64'd150);
      chk("w1_stamp", 64'(out_stamp), 64'd5);
      chk("w1_count", 64'(count), 64'd1);
      repeat (3) tick();
      chk("hold_reg", 64'(out_reg), 64'd2);
      chk("hold_data", 64'(out_data), 64'd150);
      chk("hold_stamp", 64'(out_stamp), 64'd5);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pop1_valid", 64'(out_valid), 64'd0);
      chk("pop1_count", 64'(count), 64'd0);

      // clear to restart stamp at 0
      clear = 1'b1;
      tick();
      clear = 1'b0;

      // 3: 17 writes, stamps 0..16, last one dropped
      for (int i = 0; i < 17; i++) begin
         wr(5'(i + 1), 32'h1000 + 32'(i));
      end
      chk("full_count", 64'(count), 64'd16);
      chk("full_ovf", 64'(overflow), 64'd1);
      chk("full_drop", 64'(drop_count), 64'd1);
      chk("full_head", 64'(out_data), 64'h1000);

      // 4: full + push + pop at stamp 17
      out_ready = 1'b1;
      wr(5'd20, 32'hABCD);
      chk("fpp_count", 64'(count), 64'd16);
      chk("fpp_drop", 64'(drop_count), 64'd1);
      for (int i = 1; i < 16; i++) begin
         chk("drain_reg", 64'(out_reg), 64'(i + 1));
         chk("drain_data", 64'(out_data), 64'h1000 + 64'(i));
         chk("drain_stamp", 64'(out_stamp), 64'(i));
         tick();
      end
      chk("tail_reg", 64'(out_reg), 64'd20);
      chk("tail_data", 64'(out_data), 64'hABCD);
      chk("tail_stamp", 64'(out_stamp), 64'd17);
      tick();
      out_ready = 1'b0;
      chk("drained", 64'(count), 64'd0);
      chk("ovf_sticky", 64'(overflow), 64'd1);

      // 5: clear with 5 held and a write pending
      for (int i = 0; i < 5; i++) begin
         wr(5'(i + 3), 32'(i));
      end
      chk("five", 64'(count), 64'd5);
      clear = 1'b1;
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = 5'd9;
      data_writeReg = 32'd77;
      tick();
      clear = 1'b0;
      ctrl_writeEnable = 1'b0;
      chk("clr_count", 64'(count), 64'd0);
      chk("clr_valid", 64'(out_valid), 64'd0);
      chk("clr_drop", 64'(drop_count), 64'd0);
      chk("clr_ovf", 64'(overflow), 64'd0);
      wr(5'd10, 32'd55);
      chk("clr_stamp", 64'(out_stamp), 64'd0);
      chk("clr_lost", 64'(count), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // 6: write to register 0
      wr(5'd0, 32'd7);
`ifdef TRACE_SKIP_R0_EN
      chk("r0_count", 64'(count), 64'd0);
      chk("r0_drop", 64'(drop_count), 64'd0);
`else
      chk("r0_count", 64'(count), 64'd1);
      chk("r0_data", 64'(out_data), 64'd7);
`endif

      // async reset mid-operation
      wr(5'd11, 32'd1);
      wr(5'd12, 32'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_data", 64'(out_data), 64'd0);
      tick();
      reset = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
